cam_array_seq: RTL and testbench
================================

// Module: cam_array_seq
// PURPOSE
//   Command sequencer for one cell_R-style CAM storage array. Accepts one command at a time and drives
//   the array's mode, address, input-enable and data lines to load, read out, clear or copy the array.
//   Loads and reads run row-by-row (one row per beat) or column-by-column (one column per beat).
//   Sits between the AP top-level controller / host DMA and the array; idle mode leaves the array in
//   compute (default) mode.
// PARAMETERS
//   DATA_WIDTH      4   bits per row (= number of columns)
//   DATA_DEPTH      4   rows (= bits per column)
//   ADDR_WIDTH_CAM  8   array address width; must hold max(DATA_DEPTH,DATA_WIDTH)+3
//   RowxRow 3'd1, ColxCol 3'd2, COPY_B 3'd3, COPY_A 3'd5, RST0 3'd6   array mode codes, same values as the array
// PORTS
//   clk              in   1                       clock, all state on rising edge
//   rst              in   1                       synchronous reset, active-high
//   cmd_valid        in   1                       command offered
//   cmd_ready        out  1                       1 only in IDLE
//   cmd_op           in   3                       0 LOAD_ROW,1 LOAD_COL,2 READ_ROW,3 READ_COL,4 CLEAR,5 COPY_A,6 COPY_B,7 illegal
//   wr_valid         in   1                       load beat offered
//   wr_ready         out  1                       1 in WRITE state
//   wr_row_data      in   DATA_WIDTH              row beat (LOAD_ROW)
//   wr_col_data      in   DATA_DEPTH              column beat (LOAD_COL)
//   rd_valid         out  1                       read beat valid (no backpressure)
//   rd_row_data      out  DATA_WIDTH              row beat (READ_ROW)
//   rd_col_data      out  DATA_DEPTH              column beat (READ_COL)
//   rd_last          out  1                       with rd_valid on the final beat
//   done             out  1                       1-cycle pulse when a command completes
//   err              out  1                       1-cycle pulse with done for illegal op 7
//   busy             out  1                       state != IDLE
//   input_mode       out  3                       to array
//   rst_In           out  1                       to array; 0 = write/copy enable
//   addr_input_rbr / addr_input_cbc    out  ADDR_WIDTH_CAM   to array
//   addr_output_rbr / addr_output_cbc  out  ADDR_WIDTH_CAM   to array
//   input_row out DATA_WIDTH; input_col out DATA_DEPTH       to array (wr data pass-through)
//   Q_out_row in DATA_WIDTH; Q_out_col in DATA_DEPTH         from array
// BEHAVIOUR
//   - States: IDLE, WRITE, READ, DRAIN, ONESHOT, DONE. Beat count N = DATA_DEPTH (row ops), DATA_WIDTH (col ops).
//   - Reset (and IDLE): input_mode=0, rst_In=1, input addrs=0, addr_output_rbr=DATA_DEPTH+3,
//     addr_output_cbc=DATA_WIDTH+3 (array output-disable sentinel), rd_valid/rd_last/done/err=0, idx=0.
//   - IDLE: cmd_valid&cmd_ready latches op; 0/1 -> WRITE, 2/3 -> READ, 4/5/6 -> ONESHOT, 7 -> DONE with err.
//   - WRITE: input_mode=RowxRow/ColxCol, addr_input_rbr/cbc=idx. rst_In = ~wr_valid (combinational);
//     input_row/input_col = wr data (combinational). Array captures on the handshake edge. idx++ per beat;
//     beat idx==N-1 -> DONE. wr_valid low: array holds (rst_In=1), no timeout.
//   - READ: input_mode held RowxRow/ColxCol, rst_In=1; addr_output_rbr/cbc=idx, idx++ every cycle, N cycles -> DRAIN.
//     Array output latency is 2 cycles: beat for address k appears on Q_out_* 2 cycles after address k is driven;
//     2-deep valid/last shift pipe registers rd_valid, rd_last; rd_*_data = Q_out_* while rd_valid.
//   - DRAIN: address = sentinel, mode held, 2 cycles, last beat emitted -> DONE. rd beats strictly consecutive.
//   - ONESHOT (1 cycle): CLEAR -> input_mode=RST0; COPY_A/COPY_B -> input_mode=COPY_A/COPY_B, rst_In=0. -> DONE.
//   - DONE (1 cycle): done=1 (err=1 if op 7), mode back to 0 -> IDLE. Next cmd accepted earliest cycle after DONE.
//   - rst mid-operation: next cycle IDLE outputs, in-flight read beats discarded (rd_valid=0), partial load
//     left in array as written; no done pulse.
//   - Command while busy: ignored (cmd_ready=0). wr_valid outside WRITE: ignored, wr_ready=0.
// CONFIGURATION
//   CAM_SEQ_STATS_EN defined: adds outputs op_count[15:0] (done pulses, wraps at 16'hFFFF->0) and
//   wr_stall_count[15:0] (WRITE cycles with wr_valid=0, saturates at 16'hFFFF); both 0 on rst.
//   Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//   LOAD_ROW beats 4'hA,5,C,3 back-to-back -> 4 writes at rows 0..3, done 1 cycle after last beat, cmd_ready next.
//   LOAD_ROW above then READ_ROW -> rd_valid 4 consecutive beats A,5,C,3, first 2 cycles after READ entry, rd_last on 3.
//   LOAD_COL 4'h1,2,4,8 with wr_valid gaps of 2 cycles -> rst_In=1 in gaps; READ_ROW returns 1,2,4,8 (identity transpose).
//   CLEAR then READ_COL -> input_mode=6 for 1 cycle; 4 beats of 0, done pulses after each command.
//   cmd_op=7 -> done+err same cycle, array untouched; rst asserted during READ beat 2 -> rd_valid 0 next cycle, IDLE.
//   CAM_SEQ_STATS_EN: 3 commands with 5 stall cycles -> op_count=3, wr_stall_count=5; rst -> both 0.

Source files
------------

// File: rtl/cam_array_seq.sv
// Command sequencer for a cell_R-style CAM storage array: load/read row-wise or column-wise, clear, copy.
// Optional statistics counters are enabled by defining CAM_SEQ_STATS_EN.
module cam_array_seq #(
  parameter int DATA_WIDTH     = 4,
  parameter int DATA_DEPTH     = 4,
  parameter int ADDR_WIDTH_CAM = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [2:0]                cmd_op,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [DATA_WIDTH-1:0]     wr_row_data,
  input  logic [DATA_DEPTH-1:0]     wr_col_data,
  output logic                      rd_valid,
  output logic [DATA_WIDTH-1:0]     rd_row_data,
  output logic [DATA_DEPTH-1:0]     rd_col_data,
  output logic                      rd_last,
  output logic                      done,
  output logic                      err,
  output logic                      busy,
  output logic [2:0]                input_mode,
  output logic                      rst_In,
  output logic [ADDR_WIDTH_CAM-1:0] addr_input_rbr,
  output logic [ADDR_WIDTH_CAM-1:0] addr_input_cbc,
  output logic [ADDR_WIDTH_CAM-1:0] addr_output_rbr,
  output logic [ADDR_WIDTH_CAM-1:0] addr_output_cbc,
  output logic [DATA_WIDTH-1:0]     input_row,
  output logic [DATA_DEPTH-1:0]     input_col,
  input  logic [DATA_WIDTH-1:0]     Q_out_row,
  input  logic [DATA_DEPTH-1:0]     Q_out_col
`ifdef CAM_SEQ_STATS_EN
  ,
  output logic [15:0]               op_count,
  output logic [15:0]               wr_stall_count
`endif
);

  localparam logic [2:0] MODE_ROWXROW = 3'd1;
  localparam logic [2:0] MODE_COLXCOL = 3'd2;
  localparam logic [2:0] MODE_COPY_B  = 3'd3;
  localparam logic [2:0] MODE_COPY_A  = 3'd5;
  localparam logic [2:0] MODE_RST0    = 3'd6;

  localparam logic [2:0] OP_LOAD_ROW = 3'd0;
  localparam logic [2:0] OP_LOAD_COL = 3'd1;
  localparam logic [2:0] OP_READ_ROW = 3'd2;
  localparam logic [2:0] OP_READ_COL = 3'd3;
  localparam logic [2:0] OP_CLEAR    = 3'd4;
  localparam logic [2:0] OP_COPY_A   = 3'd5;
  localparam logic [2:0] OP_COPY_B   = 3'd6;
  localparam logic [2:0] OP_ILLEGAL  = 3'd7;

  localparam int MAX_N = (DATA_DEPTH > DATA_WIDTH) ? DATA_DEPTH : DATA_WIDTH;
  localparam int IDX_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  localparam logic [IDX_W-1:0] LAST_ROW_IDX = IDX_W'(DATA_DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_COL_IDX = IDX_W'(DATA_WIDTH - 1);

  // Out-of-range output addresses disable the array's read ports.
  localparam logic [ADDR_WIDTH_CAM-1:0] SENT_ROW = ADDR_WIDTH_CAM'(DATA_DEPTH + 3);
  localparam logic [ADDR_WIDTH_CAM-1:0] SENT_COL = ADDR_WIDTH_CAM'(DATA_WIDTH + 3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_ONESHOT,
    S_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [2:0]       op_reg, op_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [1:0]       vpipe_reg, lpipe_reg;
  logic             rd_issue, rd_issue_last;
  logic             row_op;
  logic [IDX_W-1:0] last_idx;

  assign row_op   = (op_reg == OP_LOAD_ROW) || (op_reg == OP_READ_ROW);
  assign last_idx = row_op ? LAST_ROW_IDX : LAST_COL_IDX;

  always_comb begin
    state_next      = state_reg;
    op_next         = op_reg;
    idx_next        = idx_reg;
    cmd_ready       = 1'b0;
    wr_ready        = 1'b0;
    done            = 1'b0;
    err             = 1'b0;
    input_mode      = 3'd0;
    rst_In          = 1'b1;
    addr_input_rbr  = '0;
    addr_input_cbc  = '0;
    addr_output_rbr = SENT_ROW;
    addr_output_cbc = SENT_COL;
    input_row       = '0;
    input_col       = '0;
    rd_issue        = 1'b0;
    rd_issue_last   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_next  = cmd_op;
          idx_next = '0;
          case (cmd_op)
            OP_LOAD_ROW, OP_LOAD_COL:       state_next = S_WRITE;
            OP_READ_ROW, OP_READ_COL:       state_next = S_READ;
            OP_CLEAR, OP_COPY_A, OP_COPY_B: state_next = S_ONESHOT;
            default:                        state_next = S_DONE;
          endcase
        end
      end

      S_WRITE: begin
        wr_ready   = 1'b1;
        input_mode = row_op ? MODE_ROWXROW : MODE_COLXCOL;
        // The array writes only while rst_In is low, so an idle beat simply holds it.
        rst_In     = ~wr_valid;
        if (row_op) begin
          addr_input_rbr = ADDR_WIDTH_CAM'(idx_reg);
          input_row      = wr_row_data;
        end else begin
          addr_input_cbc = ADDR_WIDTH_CAM'(idx_reg);
          input_col      = wr_col_data;
        end
        if (wr_valid) begin
          if (idx_reg == last_idx) begin
            idx_next   = '0;
            state_next = S_DONE;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end

      S_READ: begin
        input_mode = row_op ? MODE_ROWXROW : MODE_COLXCOL;
        if (row_op) addr_output_rbr = ADDR_WIDTH_CAM'(idx_reg);
        else        addr_output_cbc = ADDR_WIDTH_CAM'(idx_reg);
        rd_issue      = 1'b1;
        rd_issue_last = (idx_reg == last_idx);
        if (idx_reg == last_idx) begin
          idx_next   = '0;
          state_next = S_DRAIN;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end

      S_DRAIN: begin
        // Two cycles cover the array's output latency so the last beat lands before DONE.
        input_mode = row_op ? MODE_ROWXROW : MODE_COLXCOL;
        if (idx_reg == IDX_W'(1)) begin
          idx_next   = '0;
          state_next = S_DONE;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end

      S_ONESHOT: begin
        case (op_reg)
          OP_COPY_A: begin
            input_mode = MODE_COPY_A;
            rst_In     = 1'b0;
          end
          OP_COPY_B: begin
            input_mode = MODE_COPY_B;
            rst_In     = 1'b0;
          end
          default: input_mode = MODE_RST0;
        endcase
        state_next = S_DONE;
      end

      S_DONE: begin
        done       = 1'b1;
        err        = (op_reg == OP_ILLEGAL);
        state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      op_reg    <= 3'd0;
      idx_reg   <= '0;
      vpipe_reg <= 2'b00;
      lpipe_reg <= 2'b00;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      idx_reg   <= idx_next;
      vpipe_reg <= {vpipe_reg[0], rd_issue};
      lpipe_reg <= {lpipe_reg[0], rd_issue_last};
    end
  end

  assign busy        = (state_reg != S_IDLE);
  assign rd_valid    = vpipe_reg[1];
  assign rd_last     = lpipe_reg[1];
  assign rd_row_data = rd_valid ? Q_out_row : '0;
  assign rd_col_data = rd_valid ? Q_out_col : '0;

`ifdef CAM_SEQ_STATS_EN
  logic [15:0] op_count_reg, wr_stall_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_reg       <= 16'd0;
      wr_stall_count_reg <= 16'd0;
    end else begin
      if (done) op_count_reg <= op_count_reg + 16'd1;
      if ((state_reg == S_WRITE) && !wr_valid && (wr_stall_count_reg != 16'hFFFF))
        wr_stall_count_reg <= wr_stall_count_reg + 16'd1;
    end
  end

  assign op_count       = op_count_reg;
  assign wr_stall_count = wr_stall_count_reg;
`endif

endmodule

// File: tb/tb_cam_array_seq.sv
// Directed bench for cam_array_seq with a small behavioural model of the CAM array (2-cycle read latency).
// Stats checks run when CAM_SEQ_STATS_EN is defined.
module tb_cam_array_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [3:0] wr_row_data = 4'd0;
  logic [3:0] wr_col_data = 4'd0;
  logic       rd_valid;
  logic [3:0] rd_row_data;
  logic [3:0] rd_col_data;
  logic       rd_last;
  logic       done;
  logic       err;
  logic       busy;
  logic [2:0] input_mode;
  logic       rst_In;
  logic [7:0] addr_input_rbr, addr_input_cbc, addr_output_rbr, addr_output_cbc;
  logic [3:0] input_row, input_col;
  logic [3:0] Q_out_row, Q_out_col;
`ifdef CAM_SEQ_STATS_EN
  logic [15:0] op_count, wr_stall_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cam_array_seq #(.DATA_WIDTH(4), .DATA_DEPTH(4), .ADDR_WIDTH_CAM(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_row_data(wr_row_data), .wr_col_data(wr_col_data),
    .rd_valid(rd_valid), .rd_row_data(rd_row_data), .rd_col_data(rd_col_data),
    .rd_last(rd_last), .done(done), .err(err), .busy(busy),
    .input_mode(input_mode), .rst_In(rst_In),
    .addr_input_rbr(addr_input_rbr), .addr_input_cbc(addr_input_cbc),
    .addr_output_rbr(addr_output_rbr), .addr_output_cbc(addr_output_cbc),
    .input_row(input_row), .input_col(input_col),
    .Q_out_row(Q_out_row), .Q_out_col(Q_out_col)
`ifdef CAM_SEQ_STATS_EN
    , .op_count(op_count), .wr_stall_count(wr_stall_count)
`endif
  );

  // Array model: bit mem[r][c] is row r, column c.
  logic [3:0] mem [4];
  logic [3:0] q1r = 4'd0, q2r = 4'd0, q1c = 4'd0, q2c = 4'd0;
  logic [3:0] col_sel;

  initial for (int r = 0; r < 4; r++) mem[r] = 4'd0;

  always_comb begin
    col_sel = 4'd0;
    if (addr_output_cbc < 8'd4)
      for (int r = 0; r < 4; r++) col_sel[r] = mem[r][addr_output_cbc[1:0]];
  end

  always @(posedge clk) begin
    if (input_mode == 3'd1 && !rst_In && addr_input_rbr < 8'd4)
      mem[addr_input_rbr[1:0]] <= input_row;
    else if (input_mode == 3'd2 && !rst_In && addr_input_cbc < 8'd4)
      for (int r = 0; r < 4; r++) mem[r][addr_input_cbc[1:0]] <= input_col[r];
    else if (input_mode == 3'd6)
      for (int r = 0; r < 4; r++) mem[r] <= 4'd0;
    q1r <= (addr_output_rbr < 8'd4) ? mem[addr_output_rbr[1:0]] : 4'd0;
    q2r <= q1r;
    q1c <= col_sel;
    q2c <= q1c;
  end

  assign Q_out_row = q2r;
  assign Q_out_col = q2c;

  // Observations of one read command, cycle 0 = first READ cycle.
  logic       obs_valid [8];
  logic       obs_last  [8];
  logic       obs_done  [8];
  logic [3:0] obs_data  [8];
  logic [7:0] obs_addr  [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for IDLE, offers op for one cycle; returns in the first cycle of the new state.
  task automatic issue_cmd(input logic [2:0] op);
    int waited = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 20) begin
      tick();
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL cmd_ready_timeout: got %0b, required 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    tick();
    cmd_valid = 1'b0;
    $display("cmd op=%0d issued at %0t", op, $time);
  endtask

  task automatic do_read(input bit row);
    issue_cmd(row ? 3'd2 : 3'd3);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      obs_valid[k] = rd_valid;
      obs_last[k]  = rd_last;
      obs_done[k]  = done;
      obs_data[k]  = row ? rd_row_data : rd_col_data;
      obs_addr[k]  = row ? addr_output_rbr : addr_output_cbc;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_valid = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %0b, required 1", cmd_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b, required 0", busy); end
    n_cmp++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %0b, required 0", wr_ready); end
    n_cmp++; if (input_mode !== 3'd0) begin n_fail++; $display("FAIL reset_mode: got %0d, required 0", input_mode); end
    n_cmp++; if (rst_In !== 1'b1) begin n_fail++; $display("FAIL reset_rst_In: got %0b, required 1", rst_In); end
    n_cmp++; if (addr_output_rbr !== 8'd7 || addr_output_cbc !== 8'd7) begin
      n_fail++; $display("FAIL reset_out_addr: got %0d/%0d, required 7/7", addr_output_rbr, addr_output_cbc); end
    n_cmp++; if (addr_input_rbr !== 8'd0 || addr_input_cbc !== 8'd0) begin
      n_fail++; $display("FAIL reset_in_addr: got %0d/%0d, required 0/0", addr_input_rbr, addr_input_cbc); end
    n_cmp++; if ({rd_valid, rd_last, done, err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b, required 0000", {rd_valid, rd_last, done, err}); end
`ifdef CAM_SEQ_STATS_EN
    n_cmp++; if (op_count !== 16'd0 || wr_stall_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_stats: got %0d/%0d, required 0/0", op_count, wr_stall_count); end
`endif
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic test_load_row();
    logic [3:0] d [4];
    d[0] = 4'hA; d[1] = 4'h5; d[2] = 4'hC; d[3] = 4'h3;
    issue_cmd(3'd0);
    for (int i = 0; i < 4; i++) begin
      wr_valid    = 1'b1;
      wr_row_data = d[i];
      @(negedge clk);
      n_cmp++; if (wr_ready !== 1'b1 || rst_In !== 1'b0 || input_mode !== 3'd1) begin
        n_fail++; $display("FAIL load_row_ctrl beat %0d: got ready=%0b rst_In=%0b mode=%0d, required 1/0/1", i, wr_ready, rst_In, input_mode); end
      n_cmp++; if (addr_input_rbr !== 8'(i) || input_row !== d[i]) begin
        n_fail++; $display("FAIL load_row_data beat %0d: got addr=%0d row=%h, required %0d/%h", i, addr_input_rbr, input_row, i, d[i]); end
      tick();
    end
    wr_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (done !== 1'b1 || err !== 1'b0) begin
      n_fail++; $display("FAIL load_row_done: got done=%0b err=%0b, required 1/0", done, err); end
    tick();
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL load_row_idle: got ready=%0b done=%0b, required 1/0", cmd_ready, done); end
  endtask

  task automatic test_read_back(input bit row, input logic [3:0] e0, e1, e2, e3, input string tag);
    logic [3:0] e [4];
    logic       ev;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    do_read(row);
    for (int k = 0; k < 8; k++) begin
      ev = (k >= 2 && k <= 5);
      n_cmp++; if (obs_valid[k] !== ev) begin
        n_fail++; $display("FAIL %s_valid cyc %0d: got %0b, required %0b", tag, k, obs_valid[k], ev); end
      if (ev) begin
        n_cmp++; if (obs_data[k] !== e[k-2]) begin
          n_fail++; $display("FAIL %s_data beat %0d: got %h, required %h", tag, k - 2, obs_data[k], e[k-2]); end
      end
      n_cmp++; if (obs_last[k] !== (k == 5)) begin
        n_fail++; $display("FAIL %s_last cyc %0d: got %0b, required %0b", tag, k, obs_last[k], k == 5); end
      n_cmp++; if (obs_done[k] !== (k == 6)) begin
        n_fail++; $display("FAIL %s_done cyc %0d: got %0b, required %0b", tag, k, obs_done[k], k == 6); end
      if (k < 4) begin
        n_cmp++; if (obs_addr[k] !== 8'(k)) begin
          n_fail++; $display("FAIL %s_addr cyc %0d: got %0d, required %0d", tag, k, obs_addr[k], k); end
      end
    end
  endtask

  task automatic test_illegal();
    issue_cmd(3'd7);
    @(negedge clk);
    n_cmp++; if (done !== 1'b1 || err !== 1'b1) begin
      n_fail++; $display("FAIL illegal_pulse: got done=%0b err=%0b, required 1/1", done, err); end
    n_cmp++; if (rst_In !== 1'b1 || input_mode !== 3'd0) begin
      n_fail++; $display("FAIL illegal_array: got rst_In=%0b mode=%0d, required 1/0", rst_In, input_mode); end
    tick();
    @(negedge clk);
    n_cmp++; if (err !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL illegal_after: got err=%0b ready=%0b, required 0/1", err, cmd_ready); end
  endtask

  task automatic test_load_col_gaps();
    logic [3:0] d [4];
    d[0] = 4'h1; d[1] = 4'h2; d[2] = 4'h4; d[3] = 4'h8;
    issue_cmd(3'd1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        for (int g = 0; g < 2; g++) begin
          wr_valid = 1'b0;
          @(negedge clk);
          n_cmp++; if (rst_In !== 1'b1 || wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL load_col_gap %0d: got rst_In=%0b ready=%0b, required 1/1", i, rst_In, wr_ready); end
          tick();
        end
      end
      wr_valid    = 1'b1;
      wr_col_data = d[i];
      @(negedge clk);
      n_cmp++; if (rst_In !== 1'b0 || input_mode !== 3'd2 || addr_input_cbc !== 8'(i) || input_col !== d[i]) begin
        n_fail++; $display("FAIL load_col_beat %0d: got rst_In=%0b mode=%0d addr=%0d col=%h, required 0/2/%0d/%h",
                           i, rst_In, input_mode, addr_input_cbc, input_col, i, d[i]); end
      tick();
    end
    wr_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL load_col_done: got %0b, required 1", done); end
    tick();
  endtask

  task automatic test_clear();
    issue_cmd(3'd4);
    @(negedge clk);
    n_cmp++; if (input_mode !== 3'd6 || done !== 1'b0) begin
      n_fail++; $display("FAIL clear_mode: got mode=%0d done=%0b, required 6/0", input_mode, done); end
    tick();
    @(negedge clk);
    n_cmp++; if (done !== 1'b1 || input_mode !== 3'd0) begin
      n_fail++; $display("FAIL clear_done: got done=%0b mode=%0d, required 1/0", done, input_mode); end
    tick();
  endtask

  task automatic test_rst_mid_read();
    issue_cmd(3'd2);
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL rst_read_beat2: got %0b, required 1", rd_valid); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (rd_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_read_idle: got valid=%0b busy=%0b ready=%0b, required 0/0/1", rd_valid, busy, cmd_ready); end
    n_cmp++; if (addr_output_rbr !== 8'd7 || input_mode !== 3'd0) begin
      n_fail++; $display("FAIL rst_read_outs: got addr=%0d mode=%0d, required 7/0", addr_output_rbr, input_mode); end
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      n_cmp++; if (rd_valid !== 1'b0 || done !== 1'b0) begin
        n_fail++; $display("FAIL rst_read_quiet cyc %0d: got valid=%0b done=%0b, required 0/0", k, rd_valid, done); end
    end
    tick();
  endtask

`ifdef CAM_SEQ_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    issue_cmd(3'd0);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < ((i == 0) ? 2 : (i == 2) ? 3 : 0); g++) begin
        wr_valid = 1'b0;
        tick();
      end
      wr_valid    = 1'b1;
      wr_row_data = 4'hF;
      tick();
    end
    wr_valid = 1'b0;
    issue_cmd(3'd4);
    issue_cmd(3'd7);
    tick();
    @(negedge clk);
    n_cmp++; if (op_count !== 16'd3 || wr_stall_count !== 16'd5) begin
      n_fail++; $display("FAIL stats_counts: got %0d/%0d, required 3/5", op_count, wr_stall_count); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (op_count !== 16'd0 || wr_stall_count !== 16'd0) begin
      n_fail++; $display("FAIL stats_reset: got %0d/%0d, required 0/0", op_count, wr_stall_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_row();
    test_read_back(1'b1, 4'hA, 4'h5, 4'hC, 4'h3, "read_row");
    test_illegal();
    test_read_back(1'b1, 4'hA, 4'h5, 4'hC, 4'h3, "read_after_illegal");
    test_load_col_gaps();
    test_read_back(1'b1, 4'h1, 4'h2, 4'h4, 4'h8, "read_transpose");
    test_clear();
    test_read_back(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, "read_col_cleared");
    test_rst_mid_read();
`ifdef CAM_SEQ_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
